uart_bus_responder: RTL and testbench

Register-mapped 8N1 UART that answers the bench's four-register parallel bus (we/ce/adr/dat) and converts between that bus and the serial rx/tx lines. It is the bus-side responder to the test bench's register initiator. It holds a 1-deep transmit holding buffer in front of a transmit shifter, and a receive shifter feeding a 1-deep receive buffer. A level interrupt reports receive-ready and transmit-empty conditions.

---
 rtl/uart_bus_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_bus_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_responder.sv
// uart_bus_responder: register-mapped 8N1 UART answering a four-register we/ce/adr/dat bus.
// A 1-deep TX holding buffer feeds the TX shifter; the RX shifter feeds a 1-deep RX buffer.
module uart_bus_responder #(
  parameter logic [7:0] DIV_RESET = 8'd15
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       ce,
  input  logic       we,
  input  logic [1:0] adr,
  inout  wire  [7:0] dat,
  input  logic       rx,
  output logic       tx,
  input  logic       dis_int,
  output logic       inter
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic       wr_en, rd_en, data_rd, status_rd;
  logic [7:0] rd_data;

  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] div_q, div_d;
  logic [7:0] txbuf_q, txbuf_d;
  logic       txbuf_empty_q, txbuf_empty_d;
  logic [7:0] rxbuf_q, rxbuf_d;
  logic       rx_full_q, rx_full_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       inter_q, inter_d;

  tx_state_t  tx_state_q, tx_state_d;
  logic [7:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_q, tx_d;
  logic       tx_load;
  logic       tx_busy;

  rx_state_t  rx_state_q, rx_state_d;
  logic [7:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic       rx_done;

  assign wr_en     = ce & we;
  assign rd_en     = ce & ~we;
  assign data_rd   = rd_en & (adr == 2'd0);
  assign status_rd = rd_en & (adr == 2'd1);
  assign tx_busy   = (tx_state_q != TX_IDLE);

  assign dat   = rd_en ? rd_data : {8{1'bz}};
  assign tx    = tx_q;
  assign inter = inter_q;

  // Combinational read mux straight from the registers.
  always_comb begin
    rd_data = 8'd0;
    case (adr)
      2'd0:    rd_data = rxbuf_q;
      2'd1:    rd_data = {3'd0, frame_err_q, rx_overrun_q, tx_busy, txbuf_empty_q, rx_full_q};
      2'd2:    rd_data = {6'd0, ctrl_q};
      2'd3:    rd_data = div_q;
      default: rd_data = 8'd0;
    endcase
  end

  // TX next state: start, 8 data bits LSB first, stop; chains into a new frame when TXBUF is full.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!txbuf_empty_q) begin
          tx_load    = 1'b1;
          tx_state_d = TX_START;
          tx_cnt_d   = div_q;
          tx_sh_d    = txbuf_q;
          tx_d       = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 8'd0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = div_q;
          tx_bit_d   = 3'd0;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 8'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == 8'd0) begin
          tx_cnt_d = div_q;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 8'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 8'd0) begin
          if (!txbuf_empty_q) begin
            tx_load    = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = div_q;
            tx_sh_d    = txbuf_q;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 8'd1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // RX next state: half-bit start check, then mid-bit samples of data and stop.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = div_q >> 1;
        end else begin
          rx_cnt_d = rx_cnt_q;
        end
      end
      RX_START: begin
        if (rx_cnt_q != 8'd0) begin
          rx_cnt_d = rx_cnt_q - 8'd1;
        end else if (rx_sync2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = div_q;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == 8'd0) begin
          rx_sh_d    = {rx_sync2_q, rx_sh_q[7:1]};
          rx_cnt_d   = div_q;
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - 8'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == 8'd0) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 8'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Register file updates; a flag being set overrides a same-edge clear by a read.
  always_comb begin
    ctrl_d        = ctrl_q;
    div_d         = div_q;
    txbuf_d       = txbuf_q;
    txbuf_empty_d = txbuf_empty_q | tx_load;
    rxbuf_d       = rxbuf_q;
    rx_full_d     = rx_full_q & ~data_rd;
    rx_overrun_d  = rx_overrun_q & ~status_rd;
    frame_err_d   = frame_err_q & ~status_rd;
    if (wr_en) begin
      case (adr)
        2'd0: begin
          txbuf_d       = txbuf_empty_q ? dat : txbuf_q;
          txbuf_empty_d = txbuf_empty_q ? 1'b0 : txbuf_empty_q | tx_load;
        end
        2'd2:    ctrl_d = dat[1:0];
        2'd3:    div_d  = dat;
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
    if (rx_done) begin
      frame_err_d = frame_err_d | ~rx_sync2_q;
      // A DATA read on this edge frees the buffer, so the new byte is accepted.
      if (!rx_full_q || data_rd) begin
        rxbuf_d   = rx_sh_q;
        rx_full_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else begin
      rxbuf_d = rxbuf_q;
    end
    inter_d = ~dis_int & ((ctrl_q[0] & rx_full_q) | (ctrl_q[1] & txbuf_empty_q));
  end

  // Bus-visible registers and the interrupt output.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_q        <= 2'd0;
      div_q         <= DIV_RESET;
      txbuf_q       <= 8'd0;
      txbuf_empty_q <= 1'b1;
      rxbuf_q       <= 8'd0;
      rx_full_q     <= 1'b0;
      rx_overrun_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      inter_q       <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      div_q         <= div_d;
      txbuf_q       <= txbuf_d;
      txbuf_empty_q <= txbuf_empty_d;
      rxbuf_q       <= rxbuf_d;
      rx_full_q     <= rx_full_d;
      rx_overrun_q  <= rx_overrun_d;
      frame_err_q   <= frame_err_d;
      inter_q       <= inter_d;
    end
  end

  // TX and RX engine state, plus the two-flop rx synchronizer and edge history.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 8'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'd0;
      tx_q       <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 8'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_sync1_q <= rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboarded bench for uart_bus_responder: bus reads and decoded TX bytes are checked
// by monitors against expectations queued by the directed stimulus.
module tb_uart_bus_responder;

  logic       clk = 1'b0;
  logic       arst_n, ce, we, rx, dis_int;
  logic [1:0] adr;
  wire  [7:0] dat;
  logic       tx, inter;
  logic [7:0] tb_dat;
  logic       tb_drv;

  int checks = 0;
  int errors = 0;
  int bitp   = 16;
  bit tx_mon_en = 1'b0;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];

  always #5 clk = ~clk;
  assign dat = tb_drv ? tb_dat : 8'bz;

  uart_bus_responder #(.DIV_RESET(8'd15)) dut (
    .clk(clk), .arst_n(arst_n), .ce(ce), .we(we), .adr(adr), .dat(dat),
    .rx(rx), .tx(tx), .dis_int(dis_int), .inter(inter)
  );

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    ce = 1'b1; we = 1'b1; adr = a; tb_dat = d; tb_drv = 1'b1;
    cyc(1);
    ce = 1'b0; we = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    ce = 1'b1; we = 1'b0; adr = a;
    cyc(1);
    ce = 1'b0;
  endtask

  task automatic set_div(input logic [7:0] d);
    bus_write(2'd3, d);
    bitp = int'(d) + 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cyc(bitp);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(bitp);
    end
    rx = stop_bit;
    cyc(bitp);
    rx = 1'b1;
    cyc(2 * bitp);
  endtask

  // Read monitor: pops the next expected read value whenever a read is on the bus.
  always @(negedge clk) begin
    logic [7:0] e;
    string      n;
    if (ce === 1'b1 && we === 1'b0) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%h required=none", dat);
      end else begin
        e = rd_exp_q.pop_front();
        n = rd_name_q.pop_front();
        check8(n, dat, e);
      end
    end
  end

  // TX monitor: decodes each frame at mid-bit and compares with the queued byte.
  initial begin
    logic [7:0] b;
    logic       s0, s9;
    forever begin
      @(negedge tx);
      repeat (bitp / 2) @(negedge clk);
      s0 = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (bitp) @(negedge clk);
        b[i] = tx;
      end
      repeat (bitp) @(negedge clk);
      s9 = tx;
      if (tx_mon_en) begin
        check8("tx_start", {7'd0, s0}, 8'd0);
        check8("tx_stop", {7'd0, s9}, 8'd1);
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%h required=none", b);
        end else begin
          check8("tx_byte", b, tx_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] seq;
    int         n;
    arst_n = 1'b0; ce = 1'b0; we = 1'b0; adr = 2'd0; tb_dat = 8'd0; tb_drv = 1'b0;
    rx = 1'b1; dis_int = 1'b0;
    cyc(3);
    arst_n = 1'b1;
    cyc(2);
    bus_read(2'd1, 8'h02, "rst_status");
    bus_read(2'd3, 8'h0F, "rst_div");
    check8("rst_inter", {7'd0, inter}, 8'd0);

    // Reset in the middle of a frame.
    bus_write(2'd2, 8'h02);
    bus_write(2'd0, 8'h54);
    cyc(29);
    check8("mid_tx_low", {7'd0, tx}, 8'd0);
    check8("mid_inter", {7'd0, inter}, 8'd1);
    #2 arst_n = 1'b0;
    #1;
    check8("arst_tx", {7'd0, tx}, 8'd1);
    check8("arst_inter", {7'd0, inter}, 8'd0);
    cyc(2);
    arst_n = 1'b1;
    cyc(1);
    bus_read(2'd1, 8'h02, "post_rst_status");
    bus_read(2'd3, 8'h0F, "post_rst_div");
    bus_read(2'd2, 8'h00, "post_rst_ctrl");
    cyc(200);
    tx_mon_en = 1'b1;

    // Single byte with exact bit timing.
    set_div(8'd3);
    bus_read(2'd3, 8'h03, "div_rb");
    cyc(2);
    seq = {1'b1, 8'hA5, 1'b0};
    tx_exp_q.push_back(8'hA5);
    bus_write(2'd0, 8'hA5);
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      check8($sformatf("a5_cyc%0d", k), {7'd0, tx}, {7'd0, seq[k / 4]});
    end
    cyc(10);

    // Back-to-back frames, third write dropped while TXBUF is full.
    tx_exp_q.push_back(8'h11);
    tx_exp_q.push_back(8'h22);
    bus_write(2'd0, 8'h11);
    cyc(1);
    bus_write(2'd0, 8'h22);
    bus_write(2'd0, 8'h33);
    bus_read(2'd1, 8'h04, "status_busy_full");
    cyc(36);
    check8("b2b_stop", {7'd0, tx}, 8'd1);
    cyc(1);
    check8("b2b_nogap", {7'd0, tx}, 8'd0);
    cyc(55);
    bus_read(2'd1, 8'h02, "status_tx_done");
    cyc(40);

    // Receive path.
    send_frame(8'h3C, 1'b1);
    bus_read(2'd1, 8'h03, "rx_status_full");
    bus_read(2'd0, 8'h3C, "rx_data");
    bus_read(2'd1, 8'h02, "rx_status_clr");

    // Overrun plus framing error, both cleared by one STATUS read.
    send_frame(8'h5A, 1'b1);
    send_frame(8'h96, 1'b1);
    send_frame(8'hF0, 1'b0);
    bus_read(2'd1, 8'h1B, "ovr_ferr_status");
    bus_read(2'd1, 8'h03, "ovr_ferr_clr");
    bus_read(2'd0, 8'h5A, "ovr_keep_first");
    bus_read(2'd1, 8'h02, "ovr_final");

    // Framing error alone, byte still delivered.
    send_frame(8'hC3, 1'b0);
    bus_read(2'd1, 8'h13, "ferr_status");
    bus_read(2'd0, 8'hC3, "ferr_data");
    bus_read(2'd1, 8'h02, "ferr_clr");

    // One-cycle glitch is a false start.
    set_div(8'd7);
    rx = 1'b0;
    cyc(1);
    rx = 1'b1;
    cyc(100);
    bus_read(2'd1, 8'h02, "glitch_status");
    set_div(8'd3);

    // Receive interrupt with one-cycle latency.
    bus_write(2'd2, 8'h01);
    cyc(1);
    check8("rx_ie_idle", {7'd0, inter}, 8'd0);
    n = 0;
    fork
      send_frame(8'h81, 1'b1);
      begin
        while (inter !== 1'b1 && n < 80) begin
          cyc(1);
          n++;
        end
      end
    join
    checks++;
    if (n < 36 || n > 48) begin
      errors++;
      $display("FAIL rx_inter_delay actual=%0d required=36..48", n);
    end
    bus_read(2'd1, 8'h03, "rx_ie_status");
    bus_read(2'd0, 8'h81, "rx_ie_data");
    check8("inter_hold", {7'd0, inter}, 8'd1);
    cyc(1);
    check8("inter_drop", {7'd0, inter}, 8'd0);

    // Transmit-empty interrupt and the disable input.
    bus_write(2'd2, 8'h02);
    check8("tx_ie_lat", {7'd0, inter}, 8'd0);
    cyc(1);
    check8("tx_ie_on", {7'd0, inter}, 8'd1);
    dis_int = 1'b1;
    cyc(1);
    check8("dis_int", {7'd0, inter}, 8'd0);
    dis_int = 1'b0;
    cyc(1);
    check8("dis_int_off", {7'd0, inter}, 8'd1);
    bus_write(2'd2, 8'h00);
    cyc(50);

    check8("tx_queue_left", 8'(tx_exp_q.size()), 8'd0);
    check8("rd_queue_left", 8'(rd_exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
